program_loader: RTL

- Fills the 28-bit-wide program RAM from a byte stream, such as a UART receiver, so programs can be changed without rebuilding the hard-coded instruction ROM.
- Assembles each group of 4 bytes into one instruction word and writes it at incrementing addresses starting at 0.
- Holds the CPU stalled while loading and releases it when an end marker arrives.
- Sits between the byte source and the write port of the instruction memory; the CPU fetch port stays read-only.

---
 rtl/program_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: fills the instruction RAM from a byte stream.
// Every four bytes form one 28-bit word, big-endian. The top nibble of byte0 is a tag:
// 0 marks an instruction and F marks the end of the program.
// The CPU is held while a load is in progress.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN. When it is defined, an 8-bit sum
// of the instruction bytes must follow the end marker.
module program_loader #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28,
    parameter int MAX_WORDS   = 256
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iStart,
    input  logic [7:0]             iByte,
    input  logic                   iByteValid,
    output logic                   oByteReady,
    output logic                   oWriteEnable,
    output logic [ADDR_WIDTH-1:0]  oWriteAddress,
    output logic [INSTR_WIDTH-1:0] oWriteData,
    output logic                   oCpuHold,
    output logic                   oDone,
    output logic                   oError,
    output logic [ADDR_WIDTH-1:0]  oWordCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t                  state, state_next;
    logic [1:0]              byte_idx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    done_pulse;
    logic [3:0]              tag;
    logic [19:0]             word_hi;     // word bits [27:8], collected from bytes 0..2
    logic                    start_load;
    logic                    byte_take;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]              sum;
`endif

    // iStart counts only while the loader is at rest.
    assign start_load = iStart && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign byte_take  = (state == S_LOAD) && iByteValid;

    assign oError     = (state == S_ERROR);
    assign oDone      = done_pulse;
    assign oWordCount = addr;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and the per-state handshake, write and hold outputs.
    always_comb begin
        state_next   = state;
        oByteReady   = 1'b0;
        oWriteEnable = 1'b0;
        oCpuHold     = 1'b0;
        case (state)
            S_IDLE: begin
                if (iStart) state_next = S_LOAD;
            end
            S_LOAD: begin
                oCpuHold   = 1'b1;
                oByteReady = 1'b1;
                if (iByteValid) begin
                    if (byte_idx == 2'd0) begin
                        if (iByte[7:4] != 4'h0 && iByte[7:4] != 4'hF) state_next = S_ERROR;
                    end else if (byte_idx == 2'd3) begin
                        if (tag == 4'h0) begin
                            state_next = (addr >= ADDR_WIDTH'(MAX_WORDS)) ? S_ERROR : S_WRITE;
                        end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_next = S_CHECK;
`else
                            state_next = S_DONE;
`endif
                        end
                    end
                end
            end
            S_WRITE: begin
                oCpuHold     = 1'b1;
                oWriteEnable = 1'b1;
                state_next   = S_LOAD;
            end
            S_DONE: begin
                if (iStart) state_next = S_LOAD;
            end
            S_ERROR: begin
                oCpuHold = 1'b1;
                if (iStart) state_next = S_LOAD;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                oCpuHold   = 1'b1;
                oByteReady = 1'b1;
                if (iByteValid) state_next = (iByte == sum) ? S_DONE : S_ERROR;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Control registers: byte index, write address and counter, write port and done pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            byte_idx      <= 2'd0;
            addr          <= '0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
            done_pulse    <= 1'b0;
        end else begin
            done_pulse <= (state_next == S_DONE) && (state != S_DONE);
            if (start_load) begin
                byte_idx <= 2'd0;
                addr     <= '0;
            end
            if (byte_take) byte_idx <= byte_idx + 2'd1;
            // The write port is loaded only when a word is about to be written, so it stays steady otherwise.
            if (byte_take && state_next == S_WRITE) begin
                oWriteAddress <= addr;
                oWriteData    <= INSTR_WIDTH'({word_hi, iByte});
            end
            if (state == S_WRITE) addr <= addr + ADDR_WIDTH'(1);
        end
    end

    // Byte assembly: the tag and the upper word bits are captured as bytes arrive.
    always_ff @(posedge Clock) begin
        if (byte_take) begin
            case (byte_idx)
                2'd0: begin
                    tag           <= iByte[7:4];
                    word_hi[19:16] <= iByte[3:0];
                end
                2'd1:    word_hi[15:8] <= iByte;
                2'd2:    word_hi[7:0]  <= iByte;
                default: ;
            endcase
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running sum of every byte of every instruction word; it restarts with each load.
    always_ff @(posedge Clock) begin
        if (start_load) begin
            sum <= 8'h00;
        end else if (byte_take) begin
            if ((byte_idx == 2'd0 && iByte[7:4] == 4'h0) || (byte_idx != 2'd0 && tag == 4'h0))
                sum <= sum + iByte;
        end
    end
`endif

endmodule
